wallace_8x8_product: RTL and testbench



---
 rtl/mul_pkg.sv | 5 +
 rtl/wallace_csa.sv | 11 +
 rtl/wallace_8x8_product.sv | 81 ++++++++
 tb/tb_wallace_8x8_product.sv | 94 +++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared widths for the Wallace multiplier family.
package mul_pkg;
    localparam int WALLACE_OPW = 8;
    localparam int WALLACE_PW  = 16;
endpackage

// File: rtl/wallace_csa.sv
// One-bit full adder (3:2 compressor) used as the Wallace tree building block.
module wallace_csa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/wallace_8x8_product.sv
// Unsigned 8x8 Wallace-tree multiplier (8->6->4->3->2 rows) with CPA and output register.
module wallace_8x8_product
    import mul_pkg::*;
(
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [WALLACE_OPW-1:0] a,
    input  logic [WALLACE_OPW-1:0] b,
    output logic [WALLACE_PW-1:0]  z
);
    localparam int PW = WALLACE_PW;

    logic [7:0][PW-1:0] s0;
    logic [5:0][PW-1:0] s1;
    logic [3:0][PW-1:0] s2;
    logic [2:0][PW-1:0] s3;
    logic [1:0][PW-1:0] s4;
    logic [PW-1:0]      z_d;
    logic [PW-1:0]      z_q;

    for (genvar r = 0; r < WALLACE_OPW; r++) begin : g_pp
        assign s0[r] = {{(PW-WALLACE_OPW){1'b0}}, a & {WALLACE_OPW{b[r]}}} << r;
    end

    // Each 3-row group becomes a sum row and a carry row shifted one column left.
    // Bit 15 only needs its sum: the total never exceeds 16 bits, so its carry is zero.
    for (genvar g = 0; g < 2; g++) begin : g_st1
        for (genvar i = 0; i < PW-1; i++) begin : g_bit
            wallace_csa u_fa (
                .a (s0[3*g][i]), .b (s0[3*g+1][i]), .ci(s0[3*g+2][i]),
                .s (s1[2*g][i]), .co(s1[2*g+1][i+1])
            );
        end
        assign s1[2*g][PW-1]  = s0[3*g][PW-1] ^ s0[3*g+1][PW-1] ^ s0[3*g+2][PW-1];
        assign s1[2*g+1][0]   = 1'b0;
    end
    assign s1[4] = s0[6];
    assign s1[5] = s0[7];

    for (genvar g = 0; g < 2; g++) begin : g_st2
        for (genvar i = 0; i < PW-1; i++) begin : g_bit
            wallace_csa u_fa (
                .a (s1[3*g][i]), .b (s1[3*g+1][i]), .ci(s1[3*g+2][i]),
                .s (s2[2*g][i]), .co(s2[2*g+1][i+1])
            );
        end
        assign s2[2*g][PW-1]  = s1[3*g][PW-1] ^ s1[3*g+1][PW-1] ^ s1[3*g+2][PW-1];
        assign s2[2*g+1][0]   = 1'b0;
    end

    for (genvar i = 0; i < PW-1; i++) begin : g_st3
        wallace_csa u_fa (
            .a (s2[0][i]), .b (s2[1][i]), .ci(s2[2][i]),
            .s (s3[0][i]), .co(s3[1][i+1])
        );
    end
    assign s3[0][PW-1] = s2[0][PW-1] ^ s2[1][PW-1] ^ s2[2][PW-1];
    assign s3[1][0]    = 1'b0;
    assign s3[2]       = s2[3];

    for (genvar i = 0; i < PW-1; i++) begin : g_st4
        wallace_csa u_fa (
            .a (s3[0][i]), .b (s3[1][i]), .ci(s3[2][i]),
            .s (s4[0][i]), .co(s4[1][i+1])
        );
    end
    assign s4[0][PW-1] = s3[0][PW-1] ^ s3[1][PW-1] ^ s3[2][PW-1];
    assign s4[1][0]    = 1'b0;

    assign z_d = s4[0] + s4[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;
endmodule

// File: tb/tb_wallace_8x8_product.sv
// Self-checking bench for wallace_8x8_product: directed literals plus exhaustive sweep vs arithmetic model.
module tb_wallace_8x8_product;
    logic        clk;
    logic        clrn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] z;
    logic [15:0] exp_z;
    logic        chk_en;
    int          n_pass;
    int          n_total;

    wallace_8x8_product dut (
        .clk (clk),
        .clrn(clrn),
        .a   (a),
        .b   (b),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: z holds last captured a*b, zero while cleared.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) exp_z = 16'h0000;
        else       exp_z = a * b;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h (a=%h b=%h)", name, act, req, a, b);
    endtask

    always @(negedge clk) begin
        if (chk_en) check("model", z, exp_z);
    end

    logic [15:0] walk_exp [6];

    initial begin
        walk_exp = '{16'h01FE, 16'h03FC, 16'h07F8, 16'h0FF0, 16'h1FE0, 16'h3FC0};
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        clrn = 1'b0; a = 8'hFF; b = 8'hFF;

        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("reset_hold", z, 16'h0000);
        end
        @(negedge clk); clrn = 1'b1;
        @(posedge clk); #1;
        check("reset_release", z, 16'hFE01);

        @(negedge clk); a = 8'h00; b = 8'h01;
        @(posedge clk); #1; check("zero", z, 16'h0000);
        @(negedge clk); a = 8'hFF; b = 8'h01;
        @(posedge clk); #1; check("identity", z, 16'h00FF);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk); a = 8'hFF; b = 8'h02 << k;
            @(posedge clk); #1; check("walk_one", z, walk_exp[k]);
        end

        @(negedge clk); a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1; check("max_ff", z, 16'hFE01);
        @(negedge clk); a = 8'h80; b = 8'h80;
        @(posedge clk); #1; check("max_80", z, 16'h4000);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk); a = 8'($urandom); b = 8'($urandom);
        end

        for (int n = 0; n < 65536; n++) begin
            @(negedge clk);
            clrn = 1'b1;
            a = n[15:8]; b = n[7:0];
            if (n == 30000) begin
                @(posedge clk); #2;
                clrn = 1'b0;
                #1;
                check("async_clear", z, 16'h0000);
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
